// File: rtl/mac_feeder.sv
// Sequencer feeding column 0 of the MAC array: one key-load burst per reset,
// then execute bursts of query vectors read from single-port SRAM.
module mac_feeder #(
    parameter int bw       = 8,
    parameter int pr       = 8,
    parameter int col      = 8,
    parameter int load_len = 10,
    parameter int aw       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [aw-1:0]    num_q,
    output logic             mem_rd,
    output logic [aw-1:0]    mem_addr,
    input  logic [pr*bw-1:0] mem_dout,
    output logic [pr*bw-1:0] q_out,
    output logic [1:0]       o_inst,
    output logic             busy,
    output logic             done,
    output logic             keys_loaded
);
    localparam int CW = 16;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [aw-1:0]    numq_q;
    logic             busy_q;
    logic             done_q;
    logic             keys_q;

    logic [CW-1:0]    tgt_d;
    logic [1:0]       tag_d;
    logic             zero_d;
    logic             rd_d;
    logic [aw-1:0]    addr_d;

    logic [1:0]       tag_p1_q;
    logic             zero_p1_q;
    logic [1:0]       inst_p2_q;
    logic [pr*bw-1:0] qout_p2_q;

    // Slot issue: load slots target column load_len-1-j; columns past the chain get zero words.
    always_comb begin
        tgt_d  = CW'(load_len - 1) - cnt_q;
        tag_d  = 2'b00;
        zero_d = 1'b0;
        rd_d   = 1'b0;
        addr_d = '0;
        case (state_q)
            LOAD: begin
                if (cnt_q < CW'(load_len)) begin
                    tag_d = 2'b01;
                    if (tgt_d < CW'(col)) begin
                        rd_d   = 1'b1;
                        addr_d = tgt_d[aw-1:0];
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                tag_d  = 2'b10;
                rd_d   = 1'b1;
                addr_d = aw'(col) + cnt_q[aw-1:0];
            end
            default: ;
        endcase
    end

    // LOAD runs one cycle past its last slot so a single idle gap precedes EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            numq_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            keys_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (done_q) begin
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (start) begin
                        numq_q <= num_q;
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        if (!keys_q)
                            state_q <= LOAD;
                        else if (num_q == '0)
                            state_q <= DRAIN;
                        else
                            state_q <= EXEC;
                    end
                end
                LOAD: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(load_len - 1)) begin
                        keys_q <= 1'b1;
                        if (numq_q == '0) begin
                            state_q <= DRAIN;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q == CW'(load_len)) begin
                        state_q <= EXEC;
                        cnt_q   <= '0;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(numq_q)) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(col + 2)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_p1_q  <= 2'b00;
            zero_p1_q <= 1'b0;
            inst_p2_q <= 2'b00;
            qout_p2_q <= '0;
        end else begin
            // stage 1: tag travels alongside the SRAM read
            tag_p1_q  <= tag_d;
            zero_p1_q <= zero_d;
            // stage 2: read data lands; q_out holds between slots
            inst_p2_q <= tag_p1_q;
            if (tag_p1_q != 2'b00)
                qout_p2_q <= zero_p1_q ? '0 : mem_dout;
        end
    end

    assign mem_rd      = rd_d;
    assign mem_addr    = addr_d;
    assign q_out       = qout_p2_q;
    assign o_inst      = inst_p2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign keys_loaded = keys_q;
endmodule
